// File: rtl/llbit_monitor.sv
// llbit_monitor: multi-context LL/SC reservation monitor.
// Keeps one reservation (valid, granule address, age) per hardware context.
// It snoops committed stores and successful SCs so that a write from another
// context to a reserved granule kills the reservation. Per-context flushes and
// an optional lifetime also clear reservations.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ll_we/ll_ctx/ll_addr     LL commit (sets a reservation)
//   sc_req/sc_ctx/sc_addr    SC commit (checked against the reservation)
//   st_we/st_ctx/st_addr     ordinary store commit (snooped)
//   flush[NUM_CTX]           per-context reservation clear
//   sc_done/sc_ok            registered SC result, valid for one cycle
//   sc_done_ctx              context of the reported SC
//   llbit_o[NUM_CTX]         current reservation valid bit per context
module llbit_monitor #(
    parameter int unsigned NUM_CTX   = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned GRAN_BITS = 2,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              ll_we,
    input  logic [((NUM_CTX > 1) ? $clog2(NUM_CTX) : 1)-1:0] ll_ctx,
    input  logic [ADDR_W-1:0]                                 ll_addr,
    input  logic                                              sc_req,
    input  logic [((NUM_CTX > 1) ? $clog2(NUM_CTX) : 1)-1:0] sc_ctx,
    input  logic [ADDR_W-1:0]                                 sc_addr,
    input  logic                                              st_we,
    input  logic [((NUM_CTX > 1) ? $clog2(NUM_CTX) : 1)-1:0] st_ctx,
    input  logic [ADDR_W-1:0]                                 st_addr,
    input  logic [NUM_CTX-1:0]                                flush,
    output logic                                              sc_done,
    output logic                                              sc_ok,
    output logic [((NUM_CTX > 1) ? $clog2(NUM_CTX) : 1)-1:0] sc_done_ctx,
    output logic [NUM_CTX-1:0]                                llbit_o
);

    localparam int unsigned CW    = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam int unsigned GW    = ADDR_W - GRAN_BITS;
    // A 1-bit age is kept (held at zero) when the timeout is disabled.
    localparam int unsigned AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [NUM_CTX-1:0] valid_q, valid_d;
    logic [GW-1:0]      addr_q [NUM_CTX];
    logic [GW-1:0]      addr_d [NUM_CTX];
    logic [AGE_W-1:0]   age_q  [NUM_CTX];
    logic [AGE_W-1:0]   age_d  [NUM_CTX];

    logic [GW-1:0] ll_g, sc_g, st_g;
    logic [GW-1:0] sel_addr;
    logic          sel_valid;
    logic          sel_flush;
    logic          st_hits_sc;
    logic          sc_ok_now_c;

    assign ll_g = ll_addr[ADDR_W-1:GRAN_BITS];
    assign sc_g = sc_addr[ADDR_W-1:GRAN_BITS];
    assign st_g = st_addr[ADDR_W-1:GRAN_BITS];

    // SC outcome from pre-edge state; out-of-range contexts select nothing and fail.
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_flush = 1'b0;
        for (int c = 0; c < int'(NUM_CTX); c++) begin
            if (sc_ctx == CW'(c)) begin
                sel_valid = valid_q[c];
                sel_addr  = addr_q[c];
                sel_flush = flush[c];
            end
        end
        st_hits_sc  = st_we && (st_ctx != sc_ctx) && (st_g == sc_g);
        sc_ok_now_c = sc_req && sel_valid && (sel_addr == sc_g) && !sel_flush && !st_hits_sc;
    end

    // Per-context next state, highest priority first (reset handled in the register).
    always_comb begin
        valid_d = valid_q;
        for (int c = 0; c < int'(NUM_CTX); c++) begin
            addr_d[c] = addr_q[c];
            age_d[c]  = age_q[c];
            if (flush[c]) begin
                valid_d[c] = 1'b0;
            end else if (ll_we && (ll_ctx == CW'(c))) begin
                addr_d[c]  = ll_g;
                age_d[c]   = '0;
                // A foreign write landing on the new granule in the same cycle wins.
                valid_d[c] = !((st_we && (st_ctx != CW'(c)) && (st_g == ll_g)) ||
                               (sc_ok_now_c && (sc_ctx != CW'(c)) && (sc_g == ll_g)));
            end else if (sc_req && (sc_ctx == CW'(c))) begin
                valid_d[c] = 1'b0;
            end else if ((st_we && (st_ctx != CW'(c)) && (st_g == addr_q[c])) ||
                         (sc_ok_now_c && (sc_ctx != CW'(c)) && (sc_g == addr_q[c]))) begin
                valid_d[c] = 1'b0;
            end else if ((TIMEOUT != 0) && valid_q[c] &&
                         (age_q[c] == AGE_W'(TIMEOUT - 1))) begin
                valid_d[c] = 1'b0;
            end else if ((TIMEOUT != 0) && valid_q[c]) begin
                age_d[c] = age_q[c] + AGE_W'(1);
            end
        end
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            sc_done     <= 1'b0;
            sc_ok       <= 1'b0;
            sc_done_ctx <= '0;
            for (int c = 0; c < int'(NUM_CTX); c++) begin
                addr_q[c] <= '0;
                age_q[c]  <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            sc_done     <= sc_req;
            sc_ok       <= sc_ok_now_c;
            sc_done_ctx <= sc_ctx;
            for (int c = 0; c < int'(NUM_CTX); c++) begin
                addr_q[c] <= addr_d[c];
                age_q[c]  <= age_d[c];
            end
        end
    end

    assign llbit_o = valid_q;

endmodule
